imem_load_ctrl: RTL

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_ctrl_if.sv | 29 ++
 rtl/imem_load_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/imem_load_ctrl_if.sv
// Byte-stream loader bus: load request, byte source handshake, instruction memory write port
// and status back to the host.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LEN_W  = 6
);
  logic              load_start;
  logic [LEN_W-1:0]  load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [7:0]        load_sum;

  modport master (
    output load_start, load_len, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, load_sum
  );

  modport slave (
    input  load_start, load_len, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, load_sum
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Program loader: streams a little-endian byte image into instruction memory while holding the
// core, with length validation, idle timeout and a running modulo-256 checksum.
module imem_load_ctrl #(
  parameter int unsigned DEPTH_BYTES = 32,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_load_ctrl_if.slave bus_io
);
  localparam int unsigned ADDR_W = $clog2(DEPTH_BYTES);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned IdleW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic [7:0]          sum_q, sum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                err_pulse_q, err_pulse_d;

  logic len_ok, accept, last_byte, idle_hit, start;

  assign len_ok    = (bus_io.load_len != '0) && (bus_io.load_len[1:0] == 2'b00) &&
                     (bus_io.load_len <= LEN_W'(DEPTH_BYTES));
  assign accept    = (state_q == StLoad) && bus_io.byte_valid;
  assign last_byte = (cnt_q == len_q - 1'b1);
  assign idle_hit  = (idle_q == IdleW'(TIMEOUT - 1));
  assign start     = ((state_q == StIdle) || (state_q == StErr)) && bus_io.load_start && len_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      idle_q      <= '0;
      sum_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      idle_q      <= idle_d;
      sum_q       <= sum_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Acceptance is tested before the idle limit so a last byte arriving on the timeout cycle wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StErr: if (start) state_d = StLoad;
      StLoad: begin
        if (accept) begin
          if (last_byte) state_d = StDone;
        end else if (idle_hit) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    idle_d      = idle_q;
    sum_d       = sum_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_pulse_d = (state_q == StIdle) && bus_io.load_start && !len_ok;
    if (start) begin
      cnt_d  = '0;
      idle_d = '0;
      sum_d  = '0;
      len_d  = bus_io.load_len;
    end else if (accept) begin
      we_d    = 1'b1;
      addr_d  = cnt_q[ADDR_W-1:0];
      wdata_d = bus_io.byte_data;
      sum_d   = sum_q + bus_io.byte_data;
      cnt_d   = cnt_q + 1'b1;
      idle_d  = '0;
    end else if (state_q == StLoad) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_comb begin
    bus_io.byte_ready = (state_q == StLoad);
    bus_io.cpu_hold   = (state_q != StIdle);
    bus_io.load_done  = (state_q == StDone);
    bus_io.load_err   = (state_q == StErr) || err_pulse_q;
    bus_io.mem_we     = we_q;
    bus_io.mem_addr   = addr_q;
    bus_io.mem_wdata  = wdata_q;
    bus_io.load_sum   = sum_q;
  end
endmodule
